// File: rtl/seg_bcd_display.sv
// seg_bcd_display: drives six active-low 7-segment digits from a 24-bit binary value.
// A serial double-dabble engine converts one bit per clock and restarts whenever
// the input differs from the last captured value. Values above 999999 show dashes.
module seg_bcd_display #(
    parameter bit BLANK_LZ = 1'b1,
    parameter int NBITS    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] value,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy,
    output logic        ovf
);

    localparam logic [23:0] MAX_DISP  = 24'd999999;
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [6:0]  SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t           state, state_nxt;
    logic [23:0]      cap_val;
    logic             valid;
    logic [NBITS-1:0] bin_sr;
    logic [23:0]      bcd;
    logic [4:0]       cnt;
    logic             ovf_pending;
    logic [5:0][6:0]  hex_q;

    logic             start;
    logic             last_shift;
    logic             lead;
    logic [23:0]      bcd_adj;
    logic [23:0]      bcd_nxt;
    logic [5:0][6:0]  seg_nxt;

    // Double-dabble correction: a nibble of 5..9 becomes 8..12, which still fits 4 bits.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Active-low segment pattern for one decimal digit (bit0 = a ... bit6 = g).
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_DASH;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture -> 20 shifts -> one load cycle -> idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes, one shift step of the converter, and the decoded display image.
    always_comb begin
        start      = (state == IDLE) && (!valid || (value != cap_val));
        last_shift = (state == SHIFT) && (cnt == 5'd1);
        bcd_adj    = '0;
        for (int i = 0; i < 6; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
        end
        bcd_nxt = 24'({bcd_adj, bin_sr[NBITS-1]});
        // A digit is a leading zero when it and every digit above it are zero;
        // the units digit always shows so that zero reads as "0".
        seg_nxt = '0;
        lead    = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            lead = lead && (bcd[4*i +: 4] == 4'd0);
            if (ovf_pending) begin
                seg_nxt[i] = SEG_DASH;
            end else if (BLANK_LZ && lead && (i != 0)) begin
                seg_nxt[i] = SEG_BLANK;
            end else begin
                seg_nxt[i] = seg7(bcd[4*i +: 4]);
            end
        end
    end

    // Converter datapath and registered outputs; the display only changes in LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_val     <= '0;
            valid       <= 1'b0;
            bin_sr      <= '0;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            ovf         <= 1'b0;
            hex_q       <= {6{SEG_BLANK}};
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_val     <= value;
                        bin_sr      <= value[NBITS-1:0];
                        bcd         <= '0;
                        valid       <= 1'b1;
                        busy        <= 1'b1;
                        cnt         <= 5'(NBITS);
                        ovf_pending <= (value > MAX_DISP);
                    end
                end
                SHIFT: begin
                    bcd    <= bcd_nxt;
                    bin_sr <= {bin_sr[NBITS-2:0], 1'b0};
                    cnt    <= cnt - 5'd1;
                end
                LOAD: begin
                    hex_q <= seg_nxt;
                    ovf   <= ovf_pending;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_seg_bcd_display.sv
// Testbench for seg_bcd_display: fixed vectors, corner sequences and random values
// compared against an arithmetic decimal-digit model.
module tb_seg_bcd_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] value;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  nz0, nz1, nz2, nz3, nz4, nz5;
    logic        busy, ovf, nz_busy, nz_ovf;
    logic [41:0] disp, nz_disp;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    seg_bcd_display #(.BLANK_LZ(1'b1), .NBITS(20)) dut (
        .clk(clk), .reset(reset), .value(value),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .busy(busy), .ovf(ovf)
    );

    seg_bcd_display #(.BLANK_LZ(1'b0), .NBITS(20)) dut_nz (
        .clk(clk), .reset(reset), .value(value),
        .hex0(nz0), .hex1(nz1), .hex2(nz2), .hex3(nz3), .hex4(nz4), .hex5(nz5),
        .busy(nz_busy), .ovf(nz_ovf)
    );

    assign disp    = {hex5, hex4, hex3, hex2, hex1, hex0};
    assign nz_disp = {nz5, nz4, nz3, nz2, nz1, nz0};

    typedef struct {
        logic [23:0] v;
        logic [41:0] hex;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    // Reference: {ovf, hex5..hex0} from decimal arithmetic.
    function automatic logic [42:0] model(input logic [23:0] v, input bit blz);
        int unsigned n = v;
        int unsigned p = 1;
        logic [42:0] r = '0;
        r[42] = (n > 999999);
        for (int i = 0; i < 6; i++) begin
            if (r[42])                          r[7*i +: 7] = 7'h3F;
            else if (blz && (i > 0) && (n < p)) r[7*i +: 7] = 7'h7F;
            else                                r[7*i +: 7] = SEG_TAB[(n / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge where busy has already been high for len0 samples.
    task automatic wait_done(input string name, input logic [41:0] hold, input int len0);
        int len = len0;
        bit held = 1'b1;
        while (busy === 1'b1 && len < 60) begin
            if (disp !== hold) held = 1'b0;
            @(negedge clk);
            if (busy === 1'b1) len++;
        end
        chk({name, " busy cycles"}, len, 21);
        chk({name, " hold"}, held, 1);
    endtask

    // Called at a negedge with the engine idle.
    task automatic convert(input string name, input logic [23:0] v);
        logic [41:0] hold;
        hold  = disp;
        value = v;
        @(negedge clk);
        chk({name, " busy rise"}, busy, 1);
        wait_done(name, hold, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [41:0] hold;
        logic [42:0] m;
        logic [23:0] v, prev;

        vecs[0] = '{24'd123456,  {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0};
        vecs[1] = '{24'd999999,  {6{7'h10}}, 1'b0};
        vecs[2] = '{24'd1000000, {6{7'h3F}}, 1'b1};
        vecs[3] = '{24'hFFFFFF,  {6{7'h3F}}, 1'b1};
        vecs[4] = '{24'd100000,  {7'h79, {5{7'h40}}}, 1'b0};
        vecs[5] = '{24'd10,      {{4{7'h7F}}, 7'h79, 7'h40}, 1'b0};
        vecs[6] = '{24'd0,       {{5{7'h7F}}, 7'h40}, 1'b0};

        // Reset state, then the automatic first conversion of zero.
        reset = 1'b1;
        value = 24'd0;
        repeat (3) @(negedge clk);
        chk("reset hex", disp, {6{7'h7F}});
        chk("reset busy", busy, 0);
        chk("reset ovf", ovf, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("zero busy rise", busy, 1);
        wait_done("zero", {6{7'h7F}}, 1);
        chk("zero disp", disp, {{5{7'h7F}}, 7'h40});
        chk("zero ovf", ovf, 0);

        // Fixed vectors.
        for (int i = 0; i < 7; i++) begin
            convert($sformatf("vec%0d", i), vecs[i].v);
            chk($sformatf("vec%0d disp", i), disp, vecs[i].hex);
            chk($sformatf("vec%0d ovf", i), ovf, vecs[i].ovf);
        end

        // Leading zeros shown when blanking is disabled.
        convert("v305", 24'd305);
        chk("v305 nz disp", nz_disp, {7'h40, 7'h40, 7'h40, 7'h30, 7'h40, 7'h12});
        chk("v305 lz disp", disp, {{3{7'h7F}}, 7'h30, 7'h40, 7'h12});

        // Input changes mid-conversion: 42 displays first, then 7 automatically.
        hold  = disp;
        value = 24'd42;
        @(negedge clk);
        chk("v42 busy rise", busy, 1);
        repeat (4) @(negedge clk);
        value = 24'd7;
        wait_done("v42", hold, 5);
        chk("v42 disp", disp, {{4{7'h7F}}, 7'h19, 7'h24});
        hold = disp;
        @(negedge clk);
        chk("v7 auto restart", busy, 1);
        wait_done("v7", hold, 1);
        chk("v7 disp", disp, {{5{7'h7F}}, 7'h78});

        // Asynchronous reset in the middle of a conversion.
        hold  = disp;
        value = 24'd555555;
        @(negedge clk);
        chk("v555555 busy rise", busy, 1);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset hex", disp, {6{7'h7F}});
        chk("midreset busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rerun busy rise", busy, 1);
        wait_done("rerun", {6{7'h7F}}, 1);
        chk("rerun disp", disp, {6{7'h12}});
        chk("rerun ovf", ovf, 0);

        // Random values against the reference model, both blanking modes.
        prev = 24'd555555;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 24'($urandom_range(0, 9));
                1:       v = 24'($urandom_range(0, 999999));
                2:       v = 24'($urandom_range(999990, 1000010));
                default: v = 24'($urandom);
            endcase
            if (v == prev) v = v ^ 24'd1;
            convert($sformatf("rnd%0d", i), v);
            m = model(v, 1'b1);
            chk($sformatf("rnd%0d disp v=%0d", i, v), disp, m[41:0]);
            chk($sformatf("rnd%0d ovf v=%0d", i, v), ovf, m[42]);
            m = model(v, 1'b0);
            chk($sformatf("rnd%0d nz disp v=%0d", i, v), nz_disp, m[41:0]);
            prev = v;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
